// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter unit: CSR address map,
// CTRL bit positions, event index map and the per-counter address decoder.
package perf_pkg;

    localparam logic [5:0] ADDR_CTRL     = 6'h00;
    localparam logic [5:0] ADDR_OVF      = 6'h01;
    localparam logic [5:0] ADDR_IRQEN    = 6'h02;
    localparam logic [5:0] ADDR_CNT_BASE = 6'h10;
    localparam logic [5:0] ADDR_CNT_END  = 6'h30;

    localparam logic [1:0] OFF_LO  = 2'd0;
    localparam logic [1:0] OFF_HI  = 2'd1;
    localparam logic [1:0] OFF_SEL = 2'd2;

    localparam int         CTRL_EN    = 0;
    localparam int         CTRL_FRZ   = 1;
    localparam logic [1:0] CTRL_RESET = 2'b01;

    typedef enum logic [3:0] {
        EVT_CYCLE    = 4'd0,
        EVT_RETIRE   = 4'd1,
        EVT_STALLF   = 4'd2,
        EVT_FLUSHD   = 4'd3,
        EVT_FLUSHE   = 4'd4,
        EVT_LOADUSE  = 4'd5,
        EVT_BR_TAKEN = 4'd6,
        EVT_MEMWR    = 4'd7
    } perf_evt_e;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
        logic [1:0] off;
    } cnt_dec_t;

    // Each counter owns a 4-word window starting at 0x10.
    function automatic cnt_dec_t decode_cnt(input logic [5:0] addr);
        cnt_dec_t   d;
        logic [5:0] sub;
        sub   = addr - ADDR_CNT_BASE;
        d.hit = (addr >= ADDR_CNT_BASE) && (addr < ADDR_CNT_END);
        d.idx = sub[4:2];
        d.off = sub[1:0];
        return d;
    endfunction

endpackage

// File: rtl/perf_counter_slice.sv
// One event counter: SEL register, event mux, LO/HI bus-write merge,
// increment and wrap detection.
module perf_counter_slice
    import perf_pkg::*;
#(
    parameter int CNT_W   = 64,
    parameter int NUM_EVT = 8,
    parameter int IDX     = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               count_en_i,
    input  logic               we_lo_i,
    input  logic               we_hi_i,
    input  logic               we_sel_i,
    input  logic [31:0]        wdata_i,
    output logic [CNT_W-1:0]   cnt_o,
    output logic [3:0]         sel_o,
    output logic               wrap_o
);

    localparam int         HI_W    = CNT_W - 32;
    localparam logic [3:0] SEL_RST = 4'(IDX % NUM_EVT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sel_q, sel_d;
    logic [15:0]      evt_ext;
    logic             hit;
    logic             inc;

    always_comb begin
        evt_ext                = '0;
        evt_ext[NUM_EVT-1:0]   = evt_i;
    end

    // A SEL value beyond the event vector selects nothing.
    assign hit    = ({1'b0, sel_q} < 5'(NUM_EVT)) && evt_ext[sel_q];
    assign inc    = count_en_i && hit && !we_lo_i && !we_hi_i;
    assign wrap_o = inc && (&cnt_q);

    always_comb begin
        cnt_d = cnt_q;
        if (we_lo_i || we_hi_i) begin
            if (we_lo_i) cnt_d[31:0]       = wdata_i;
            if (we_hi_i) cnt_d[CNT_W-1:32] = wdata_i[HI_W-1:0];
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        sel_d = we_sel_i ? wdata_i[3:0] : sel_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            sel_q <= SEL_RST;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sel_o = sel_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Performance-monitor unit: NUM_CNT selectable event counters behind a CSR
// port with atomic LO/HI reads, sticky overflow flags and an overflow IRQ.
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int NUM_CNT = 4,
    parameter int CNT_W   = 64,
    parameter int NUM_EVT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               csr_we,
    input  logic               csr_re,
    input  logic [5:0]         csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               csr_rvalid,
    output logic               irq_ovf
);

    logic [1:0]         ctrl_q, ctrl_d;
    logic [NUM_CNT-1:0] ovf_q, ovf_d;
    logic [NUM_CNT-1:0] irqen_q, irqen_d;
    logic [31:0]        shadow_q, shadow_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q;
    logic               irq_q;

    logic [CNT_W-1:0]   cnt [NUM_CNT];
    logic [3:0]         sel [NUM_CNT];
    logic [NUM_CNT-1:0] wrap;
    logic [NUM_CNT-1:0] ovf_clr;
    cnt_dec_t           dec;
    logic               cnt_sel;
    logic               count_en;
    logic [31:0]        rd_val;
    logic [31:0]        hi_zx;

    assign dec      = decode_cnt(csr_addr);
    assign cnt_sel  = dec.hit && ({1'b0, dec.idx} < 4'(NUM_CNT));
    assign count_en = ctrl_q[CTRL_EN] && !(ctrl_q[CTRL_FRZ] && (|ovf_q));

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        perf_counter_slice #(
            .CNT_W   (CNT_W),
            .NUM_EVT (NUM_EVT),
            .IDX     (g)
        ) u_slice (
            .clk        (clk),
            .reset      (reset),
            .evt_i      (evt_i),
            .count_en_i (count_en),
            .we_lo_i    (csr_we && cnt_sel && (dec.idx == 3'(g)) && (dec.off == OFF_LO)),
            .we_hi_i    (csr_we && cnt_sel && (dec.idx == 3'(g)) && (dec.off == OFF_HI)),
            .we_sel_i   (csr_we && cnt_sel && (dec.idx == 3'(g)) && (dec.off == OFF_SEL)),
            .wdata_i    (csr_wdata),
            .cnt_o      (cnt[g]),
            .sel_o      (sel[g]),
            .wrap_o     (wrap[g])
        );
    end

    // A fresh wrap wins over a same-cycle write-1-to-clear.
    assign ovf_clr = (csr_we && csr_addr == ADDR_OVF) ? csr_wdata[NUM_CNT-1:0] : '0;
    assign ovf_d   = (ovf_q & ~ovf_clr) | wrap;

    always_comb begin
        ctrl_d  = ctrl_q;
        irqen_d = irqen_q;
        if (csr_we && csr_addr == ADDR_CTRL)  ctrl_d  = csr_wdata[1:0];
        if (csr_we && csr_addr == ADDR_IRQEN) irqen_d = csr_wdata[NUM_CNT-1:0];
    end

    // Read data is taken from pre-write state so a same-cycle write is not visible.
    always_comb begin
        rd_val   = '0;
        hi_zx    = '0;
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
        if (csr_addr == ADDR_CTRL) begin
            rd_val[1:0] = ctrl_q;
        end else if (csr_addr == ADDR_OVF) begin
            rd_val[NUM_CNT-1:0] = ovf_q;
        end else if (csr_addr == ADDR_IRQEN) begin
            rd_val[NUM_CNT-1:0] = irqen_q;
        end else if (cnt_sel) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (dec.idx == 3'(i)) begin
                    hi_zx[CNT_W-33:0] = cnt[i][CNT_W-1:32];
                    case (dec.off)
                        OFF_LO:  rd_val      = cnt[i][31:0];
                        OFF_HI:  rd_val      = shadow_q;
                        OFF_SEL: rd_val[3:0] = sel[i];
                        default: rd_val      = '0;
                    endcase
                end
            end
        end
        if (csr_re) begin
            rdata_d = rd_val;
            if (cnt_sel && dec.off == OFF_LO) shadow_d = hi_zx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= CTRL_RESET;
            ovf_q    <= '0;
            irqen_q  <= '0;
            shadow_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            ovf_q    <= ovf_d;
            irqen_q  <= irqen_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            rvalid_q <= csr_re;
            irq_q    <= |(ovf_q & irqen_q);
        end
    end

    assign csr_rdata  = rdata_q;
    assign csr_rvalid = rvalid_q;
    assign irq_ovf    = irq_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Scoreboard bench for perf_counter_unit: reads push expected data, a monitor
// pops and compares whenever csr_rvalid is presented.
module tb_perf_counter_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  evt_i;
    logic        csr_we;
    logic        csr_re;
    logic [5:0]  csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic        irq_ovf;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] expq[$];
    logic [5:0]  addrq[$];
    logic        re_d = 1'b0;

    perf_counter_unit #(.NUM_CNT(4), .CNT_W(64), .NUM_EVT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .evt_i      (evt_i),
        .csr_we     (csr_we),
        .csr_re     (csr_re),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .csr_rvalid (csr_rvalid),
        .irq_ovf    (irq_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: rvalid must follow every accepted read by exactly one cycle.
    always @(posedge clk) re_d <= csr_re && !reset;

    always @(negedge clk) begin
        if (re_d || csr_rvalid) begin
            check("rvalid_timing", 32'(csr_rvalid), 32'(re_d));
            if (csr_rvalid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: got rdata 0x%08h required no response", csr_rdata);
                end else begin
                    automatic logic [5:0]  a = addrq.pop_front();
                    automatic logic [31:0] e = expq.pop_front();
                    check($sformatf("rdata@%02h", a), csr_rdata, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic we, input logic re, input logic [5:0] a,
                      input logic [31:0] wd, input logic [7:0] ev, input logic [31:0] exp);
        csr_we    = we;
        csr_re    = re;
        csr_addr  = a;
        csr_wdata = wd;
        evt_i     = ev;
        if (re && !reset) begin
            expq.push_back(exp);
            addrq.push_back(a);
        end
        tick();
        csr_we = 1'b0;
        csr_re = 1'b0;
        evt_i  = '0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        op(1'b1, 1'b0, a, d, 8'h00, 32'h0);
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] e);
        op(1'b0, 1'b1, a, 32'h0, 8'h00, e);
    endtask

    task automatic events(input int n, input logic [7:0] pat);
        for (int i = 0; i < n; i++) op(1'b0, 1'b0, 6'h00, 32'h0, pat, 32'h0);
    endtask

    initial begin
        reset = 1'b1; evt_i = '0; csr_we = 1'b0; csr_re = 1'b0;
        csr_addr = '0; csr_wdata = '0;
        repeat (3) tick();
        check("reset_irq", 32'(irq_ovf), 32'h0);
        check("reset_rvalid", 32'(csr_rvalid), 32'h0);
        check("reset_rdata", csr_rdata, 32'h0);
        reset = 1'b0;

        // 100 cycle events, default SEL and register map
        events(100, 8'h01);
        rd(6'h10, 32'd100);
        rd(6'h11, 32'h0);
        rd(6'h12, 32'h0);
        rd(6'h16, 32'h1);
        rd(6'h1A, 32'h2);
        rd(6'h00, 32'h1);
        rd(6'h02, 32'h0);
        rd(6'h03, 32'h0);
        rd(6'h13, 32'h0);
        rd(6'h20, 32'h0);

        // full wrap, overflow flag and interrupt
        wr(6'h10, 32'hFFFF_FFFF);
        wr(6'h11, 32'hFFFF_FFFF);
        wr(6'h12, 32'h0);
        wr(6'h02, 32'h1);
        events(1, 8'h01);
        check("irq_before", 32'(irq_ovf), 32'h0);
        events(1, 8'h00);
        check("irq_after_ovf", 32'(irq_ovf), 32'h1);
        rd(6'h01, 32'h1);
        rd(6'h10, 32'h0);
        rd(6'h11, 32'h0);
        wr(6'h01, 32'h1);
        events(1, 8'h00);
        check("irq_after_w1c", 32'(irq_ovf), 32'h0);
        rd(6'h01, 32'h0);

        // atomic LO/HI through the shadow
        wr(6'h10, 32'hFFFF_FFFF);
        wr(6'h11, 32'h0);
        rd(6'h10, 32'hFFFF_FFFF);
        events(2, 8'h01);
        rd(6'h11, 32'h0);
        rd(6'h10, 32'h1);
        rd(6'h11, 32'h1);

        // freeze on overflow, resume, set beats clear
        wr(6'h00, 32'h3);
        wr(6'h16, 32'h0);
        wr(6'h10, 32'hFFFF_FFFF);
        wr(6'h11, 32'hFFFF_FFFF);
        wr(6'h14, 32'h0);
        wr(6'h15, 32'h0);
        events(3, 8'h01);
        rd(6'h14, 32'h1);
        rd(6'h10, 32'h0);
        rd(6'h01, 32'h1);
        check("irq_frozen", 32'(irq_ovf), 32'h1);
        wr(6'h01, 32'h1);
        events(2, 8'h01);
        rd(6'h14, 32'h3);
        rd(6'h10, 32'h2);
        wr(6'h10, 32'hFFFF_FFFF);
        wr(6'h11, 32'hFFFF_FFFF);
        op(1'b1, 1'b0, 6'h01, 32'h1, 8'h01, 32'h0);
        rd(6'h01, 32'h1);
        rd(6'h14, 32'h4);
        wr(6'h00, 32'h1);
        wr(6'h01, 32'h1);
        events(1, 8'h00);
        check("irq_cleared", 32'(irq_ovf), 32'h0);

        // write/event/read collision, out-of-range SEL
        wr(6'h10, 32'h20);
        wr(6'h11, 32'h0);
        op(1'b1, 1'b1, 6'h10, 32'h5, 8'h01, 32'h20);
        rd(6'h10, 32'h5);
        rd(6'h11, 32'h0);
        wr(6'h1A, 32'h8);
        events(5, 8'hFF);
        rd(6'h18, 32'h0);
        rd(6'h1A, 32'h8);
        rd(6'h1C, 32'h5);

        // reset mid-count with a read in flight
        events(2, 8'h01);
        reset = 1'b1;
        op(1'b0, 1'b1, 6'h10, 32'h0, 8'h01, 32'h0);
        check("rst_rvalid", 32'(csr_rvalid), 32'h0);
        check("rst_rdata", csr_rdata, 32'h0);
        check("rst_irq", 32'(irq_ovf), 32'h0);
        reset = 1'b0;
        rd(6'h10, 32'h0);
        rd(6'h14, 32'h0);
        rd(6'h1C, 32'h0);
        rd(6'h12, 32'h0);
        rd(6'h16, 32'h1);
        rd(6'h1A, 32'h2);
        rd(6'h1E, 32'h3);
        rd(6'h00, 32'h1);
        rd(6'h01, 32'h0);
        rd(6'h02, 32'h0);

        events(2, 8'h00);
        check("queue_drained", 32'(expq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
